mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Load/store initiator that drives the single-port block-RAM interface (ren/addr/rdata/rd_valid, wen/wdata/wmask) on behalf of the core.
- Accepts one byte, half or word request at a time from the execute stage.
- Steers write data onto byte lanes, generates the write mask, waits for read data, then extracts and sign/zero-extends it.
- Returns a single-cycle response pulse.

Parameters:
- ADDR_W, 13, width of the memory-side byte address.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address; bits above ADDR_W ignored
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_signed  in  1  sign-extend load result
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned access flag; only driven with MISALIGN_TRAP_EN, else constant 0
- ren  out  1  memory read enable
- addr  out  ADDR_W  memory byte address
- rdata  in  32  memory read data
- rd_valid  in  1  memory read data valid
- wen  out  1  memory write enable
- wdata  out  32  memory write data
- wmask  out  4  byte-lane write enables

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Synchronous active-high reset: state=IDLE; req_ready=1; resp_valid, resp_err, ren, wen=0; addr, wdata, wmask, resp_rdata=0.
  - Reset mid-operation aborts the access. ren/wen are low in the cycle after the reset edge.
  - A late rd_valid arriving after reset is ignored.
- Lane convention:
  - Lane k is bits [8k+7:8k].
  - Lane k is enabled by wmask[3-k]; wmask[3] enables lane 0.
  - Lane index is addr[1:0].
- Store data steering:
  - byte: wdata = {4{req_wdata[7:0]}}
  - half: wdata = {2{req_wdata[15:0]}}
  - word: wdata = req_wdata
- Write masks:
  - byte at lane k: only wmask[3-k] set
  - half at lane 0: 4'b1100
  - half at lane 2: 4'b0011
  - word: 4'b1111
- Load extraction:
  - Shift rdata right by 8*addr[1:0].
  - Take the low 8/16/32 bits.
  - Sign-extend if req_signed, else zero-extend.
- All memory-side outputs and response outputs are registered. addr carries the full byte address.
- State machine: IDLE, STORE, LOAD_REQ, LOAD_WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, capture the request.
    - store -> STORE
    - load -> LOAD_REQ
  - STORE: wen=1 and resp_valid=1 for exactly one cycle -> IDLE.
  - LOAD_REQ: ren=1 for one cycle -> LOAD_WAIT.
  - LOAD_WAIT: ren=0.
    - On rd_valid, latch the extracted data -> RESP.
    - Otherwise hold. There is no timeout.
  - RESP: resp_valid=1 for one cycle with resp_rdata -> IDLE.
- req_ready=0 in every state except IDLE. Requests are not queued.
- Latency, with the request accepted in cycle N:
  - store: wen and resp_valid in cycle N+1; ready again in N+2
  - load: ren in N+1, rd_valid in N+2, resp_valid in N+3; ready again in N+4
- rd_valid outside LOAD_WAIT is ignored. ren and wen are never high in the same cycle.
- resp_rdata holds its value between responses.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misalignment is half with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned request goes IDLE -> RESP in cycle N+1 with resp_err=1 and resp_rdata=0.
  - No ren/wen is issued.
- Undefined:
  - Address low bits are forced to natural alignment (half clears bit 0, word clears bits 1:0) and the access proceeds.
  - resp_err is tied to 0.

Decomposition:
- Package mem_lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - the state enum
  - a lane-mask function (size, offset -> wmask)
- One combinational sub-module, mem_lsu_align, performs store steering, mask generation and load extraction/extension.

Test Plan:
- Memory word 0x100 = 0x884422F1.
  - Signed byte load @0x100 -> resp_rdata 0xFFFFFFF1 at N+3.
  - Unsigned byte @0x100 -> 0x000000F1.
- Signed half load @0x102 -> 0xFFFF8844; unsigned -> 0x00008844; ren high exactly one cycle.
- Byte store 0xAB @0x103 -> wmask 4'b0001, wdata 0xABABABAB, wen one cycle; readback word 0xAB4422F1.
- Word load @0x102:
  - with MISALIGN_TRAP_EN -> resp_err=1 at N+1, no ren.
  - without it -> addr=0x100, resp_rdata 0x884422F1.
- Back-to-back requests held valid -> req_ready low while busy; second request accepted only in IDLE.
- rst asserted in LOAD_WAIT:
  - next cycle all outputs at reset values, with no resp_valid.
  - a subsequent rd_valid pulse is ignored.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states and lane helpers.
// Lane k occupies bits [8k+7:8k] and is written when wmask[3-k] is set.
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD_REQ,
        LOAD_WAIT,
        RESP
    } state_e;

    // Encoding 2'b11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        logic [1:0] res;
        res = (size == 2'b11) ? SZ_WORD : size;
        return res;
    endfunction

    function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] offset);
        logic [1:0] res;
        case (norm_size(size))
            SZ_BYTE: res = offset;
            SZ_HALF: res = {offset[1], 1'b0};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return align_offset(size, offset) != offset;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] res;
        case (norm_size(size))
            SZ_BYTE: res = 4'b1000 >> offset;
            SZ_HALF: res = offset[1] ? 4'b0011 : 4'b1100;
            default: res = 4'b1111;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational data path: store lane replication, write-mask generation and
// load extraction with sign/zero extension.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wmask,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [1:0]       st_sz;
    logic [1:0]       ld_sz;
    logic [3:0][7:0]  st_lane;
    logic [31:0]      ld_shifted;

    assign st_sz    = norm_size(st_size);
    assign ld_sz    = norm_size(ld_size);
    assign st_wmask = lane_mask(st_sz, st_offset);

    // Replicating the datum on every lane lets the mask alone select the target bytes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign st_lane[gi] = (st_sz == SZ_BYTE) ? st_data[7:0] :
                                 (st_sz == SZ_HALF) ? st_data[8*(gi%2) +: 8] :
                                                      st_data[8*gi +: 8];
        end
    endgenerate

    assign st_wdata   = st_lane;
    assign ld_shifted = ld_rdata >> {ld_offset, 3'b000};

    always_comb begin
        ld_data = ld_shifted;
        case (ld_sz)
            SZ_BYTE: ld_data = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_HALF: ld_data = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store initiator for a single-port block RAM.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses with resp_err instead of aligning them.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ren,
    output logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rdata,
    input  logic              rd_valid,
    output logic              wen,
    output logic [31:0]       wdata,
    output logic [3:0]        wmask
);

    state_e            state_q, state_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        offset_q, offset_d;
    logic              signed_q, signed_d;

    logic [1:0]        req_off_aligned;
    logic              req_mis;
    logic [31:0]       st_wdata;
    logic [3:0]        st_wmask;
    logic [31:0]       ld_data;
    logic              unused_addr_bits;

    assign req_off_aligned  = align_offset(req_size, req_addr[1:0]);
    assign unused_addr_bits = ^req_addr[31:ADDR_W];

`ifdef MISALIGN_TRAP_EN
    assign req_mis = is_misaligned(req_size, req_addr[1:0]);
`else
    assign req_mis = 1'b0;
`endif

    mem_lsu_align u_align (
        .st_size   (req_size),
        .st_offset (req_off_aligned),
        .st_data   (req_wdata),
        .st_wdata  (st_wdata),
        .st_wmask  (st_wmask),
        .ld_size   (size_q),
        .ld_offset (offset_q),
        .ld_signed (signed_q),
        .ld_rdata  (rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        ren_d        = 1'b0;
        wen_d        = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        resp_rdata_d = resp_rdata_q;
        size_d       = size_q;
        offset_d     = offset_q;
        signed_d     = signed_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d   = norm_size(req_size);
                    offset_d = req_off_aligned;
                    signed_d = req_signed;
                    if (req_mis) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_we) begin
                        state_d      = STORE;
                        addr_d       = {req_addr[ADDR_W-1:2], req_off_aligned};
                        wdata_d      = st_wdata;
                        wmask_d      = st_wmask;
                        wen_d        = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d = LOAD_REQ;
                        addr_d  = {req_addr[ADDR_W-1:2], req_off_aligned};
                        ren_d   = 1'b1;
                    end
                end
            end
            STORE: begin
                state_d = IDLE;
            end
            LOAD_REQ: begin
                state_d = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                // No timeout: the memory is trusted to answer every read.
                if (rd_valid) begin
                    state_d      = RESP;
                    resp_rdata_d = ld_data;
                    resp_valid_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            resp_rdata_q <= '0;
            size_q       <= SZ_BYTE;
            offset_q     <= 2'b00;
            signed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ren_q        <= ren_d;
            wen_q        <= wen_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            resp_rdata_q <= resp_rdata_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            signed_q     <= signed_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign ren        = ren_q;
    assign wen        = wen_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign wmask      = wmask_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: byte-addressed reference memory, directed scenarios, then random traffic.
// Build with MISALIGN_TRAP_EN to match a design compiled with the misalignment trap.
module tb_mem_lsu;

    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              ren;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rdata;
    logic              rd_valid;
    logic              wen;
    logic [31:0]       wdata;
    logic [3:0]        wmask;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ren        (ren),
        .addr       (addr),
        .rdata      (rdata),
        .rd_valid   (rd_valid),
        .wen        (wen),
        .wdata      (wdata),
        .wmask      (wmask)
    );

    // Block RAM model: one-cycle registered read, byte-lane masked write.
    logic [31:0] mem [0:(1<<(ADDR_W-2))-1];
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rv = 1'b0;
    logic        mem_hold = 1'b0;
    logic        inject = 1'b0;
    logic [31:0] inject_data = 32'd0;
    logic [31:0] mem_wword;

    always @(posedge clk) begin
        mem_rv <= 1'b0;
        if (ren && !mem_hold) begin
            mem_rdata <= mem[addr[ADDR_W-1:2]];
            mem_rv    <= 1'b1;
        end
        if (wen) begin
            mem_wword = mem[addr[ADDR_W-1:2]];
            for (int k = 0; k < 4; k++)
                if (wmask[3-k]) mem_wword[8*k +: 8] = wdata[8*k +: 8];
            mem[addr[ADDR_W-1:2]] <= mem_wword;
        end
    end

    assign rdata    = inject ? inject_data : mem_rdata;
    assign rd_valid = mem_rv | inject;

    int ren_cycles = 0;
    int wen_cycles = 0;
    int overlap    = 0;
    always @(posedge clk) begin
        if (ren) ren_cycles++;
        if (wen) wen_cycles++;
        if (ren && wen) overlap++;
    end

    // Reference: flat byte array, little-endian lanes.
    logic [7:0] ref_mem [0:(1<<ADDR_W)-1];

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input int n, input logic sg);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a+i];
        if (sg && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
        return v[31:0];
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [31:0]       last_rdata;
    logic [31:0]       last_wdata;
    logic [3:0]        last_wmask;
    logic [ADDR_W-1:0] last_addr;
    logic              last_err;

    task automatic do_op(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd);
        int n, ea, wait_cnt, ren0, wen0;
        logic [31:0] exp;
        n  = nbytes(sz);
        ea = int'(a[ADDR_W-1:0]) & ~(n-1);
        wait_cnt = 0;
        while (req_ready !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check1("ready_before_req", req_ready, 1'b1);
        ren0 = ren_cycles;
        wen0 = wen_cycles;
        exp  = we ? 32'd0 : ref_load(ea, n, sg);
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
        req_signed = sg; req_wdata = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        last_addr  = addr;
        last_wdata = wdata;
        last_wmask = wmask;
        last_err   = resp_err;
`ifdef MISALIGN_TRAP_EN
        if (ea != int'(a[ADDR_W-1:0])) begin
            check1("mis_resp_valid", resp_valid, 1'b1);
            check1("mis_resp_err", resp_err, 1'b1);
            check("mis_resp_rdata", resp_rdata, 32'd0);
            check1("mis_ren", ren, 1'b0);
            check1("mis_wen", wen, 1'b0);
            last_rdata = resp_rdata;
            @(negedge clk);
            check1("mis_ready_after", req_ready, 1'b1);
            check1("mis_resp_valid_after", resp_valid, 1'b0);
            check("mis_mem_cycles", 32'(ren_cycles - ren0 + wen_cycles - wen0), 32'd0);
            $display("op we=%0d addr=%h size=%0d signed=%0d -> misaligned err=%0d",
                     we, a, sz, sg, last_err);
            return;
        end
`endif
        if (we) begin
            check1("st_wen", wen, 1'b1);
            check1("st_resp_valid", resp_valid, 1'b1);
            check1("st_ren", ren, 1'b0);
            check1("st_resp_err", resp_err, 1'b0);
            check("st_addr", 32'(addr), ea);
            check("st_resp_rdata", resp_rdata, 32'd0);
            last_rdata = resp_rdata;
            for (int i = 0; i < n; i++) ref_mem[ea+i] = wd[8*i +: 8];
            @(negedge clk);
            check1("st_wen_low", wen, 1'b0);
            check1("st_resp_valid_low", resp_valid, 1'b0);
            check1("st_ready_again", req_ready, 1'b1);
            check("st_mem_word", mem[ea>>2], ref_load(ea & ~3, 4, 1'b0));
            check("st_wen_cycles", 32'(wen_cycles - wen0), 32'd1);
        end else begin
            check1("ld_ren", ren, 1'b1);
            check1("ld_wen", wen, 1'b0);
            check1("ld_resp_valid_n1", resp_valid, 1'b0);
            check1("ld_ready_busy", req_ready, 1'b0);
            check("ld_addr", 32'(addr), ea);
            @(negedge clk);
            check1("ld_ren_low", ren, 1'b0);
            check1("ld_resp_valid_n2", resp_valid, 1'b0);
            @(negedge clk);
            check1("ld_resp_valid_n3", resp_valid, 1'b1);
            check1("ld_resp_err", resp_err, 1'b0);
            check("ld_rdata", resp_rdata, exp);
            last_rdata = resp_rdata;
            @(negedge clk);
            check1("ld_resp_valid_n4", resp_valid, 1'b0);
            check1("ld_ready_again", req_ready, 1'b1);
            check("ld_rdata_hold", resp_rdata, exp);
            check("ld_ren_cycles", 32'(ren_cycles - ren0), 32'd1);
        end
        $display("op we=%0d addr=%h size=%0d signed=%0d wdata=%h -> rdata=%h",
                 we, a, sz, sg, wd, last_rdata);
    endtask

    logic [31:0] exp1;
    logic [31:0] rnd_a;
    logic [1:0]  rnd_sz;
    logic        rnd_we;
    logic        rnd_sg;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_size = 2'b00; req_signed = 1'b0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check1("rst_ready", req_ready, 1'b1);
        check1("rst_ren", ren, 1'b0);
        check1("rst_wen", wen, 1'b0);
        check1("rst_resp_valid", resp_valid, 1'b0);
        check1("rst_resp_err", resp_err, 1'b0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_wmask", 32'(wmask), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            do_op(1'b1, 32'h100 + 32'(4*i), 2'b10, 1'b0, (i == 0) ? 32'h884422F1 : $urandom);

        do_op(1'b0, 32'h100, 2'b00, 1'b1, 32'd0);
        check("lb_signed_0x100", last_rdata, 32'hFFFFFFF1);
        do_op(1'b0, 32'h100, 2'b00, 1'b0, 32'd0);
        check("lbu_0x100", last_rdata, 32'h000000F1);
        do_op(1'b0, 32'h102, 2'b01, 1'b1, 32'd0);
        check("lh_signed_0x102", last_rdata, 32'hFFFF8844);
        do_op(1'b0, 32'h102, 2'b01, 1'b0, 32'd0);
        check("lhu_0x102", last_rdata, 32'h00008844);

        do_op(1'b0, 32'h102, 2'b10, 1'b0, 32'd0);
`ifdef MISALIGN_TRAP_EN
        check1("lw_0x102_err", last_err, 1'b1);
`else
        check1("lw_0x102_err", last_err, 1'b0);
        check("lw_0x102_addr", 32'(last_addr), 32'h100);
        check("lw_0x102_rdata", last_rdata, 32'h884422F1);
`endif

        do_op(1'b1, 32'h103, 2'b00, 1'b0, 32'h123456AB);
        check("sb_0x103_wmask", 32'(last_wmask), 32'h1);
        check("sb_0x103_wdata", last_wdata, 32'hABABABAB);
        do_op(1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
        check("lw_after_sb", last_rdata, 32'hAB4422F1);

        // Two requests with req_valid held high throughout.
        exp1 = ref_load(32'h104, 4, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h104; req_size = 2'b10;
        req_signed = 1'b0; req_wdata = 32'd0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h106; req_size = 2'b01; req_wdata = 32'h0000BEEF;
        check1("b2b_ready_n1", req_ready, 1'b0);
        check1("b2b_ren_n1", ren, 1'b1);
        @(negedge clk);
        check1("b2b_ready_n2", req_ready, 1'b0);
        check1("b2b_wen_n2", wen, 1'b0);
        @(negedge clk);
        check1("b2b_ready_n3", req_ready, 1'b0);
        check1("b2b_resp_valid_n3", resp_valid, 1'b1);
        check("b2b_rdata_n3", resp_rdata, exp1);
        check1("b2b_wen_n3", wen, 1'b0);
        @(negedge clk);
        check1("b2b_ready_n4", req_ready, 1'b1);
        check1("b2b_wen_n4", wen, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        check1("b2b_wen_n5", wen, 1'b1);
        check("b2b_addr_n5", 32'(addr), 32'h106);
        check("b2b_wmask_n5", 32'(wmask), 32'h3);
        check("b2b_wdata_n5", wdata, 32'hBEEFBEEF);
        ref_mem[32'h106] = 8'hEF;
        ref_mem[32'h107] = 8'hBE;
        @(negedge clk);
        check1("b2b_wen_n6", wen, 1'b0);
        check1("b2b_ready_n6", req_ready, 1'b1);
        check("b2b_mem_word", mem[32'h104 >> 2], ref_load(32'h104, 4, 1'b0));
        $display("op back-to-back load@104 rdata=%h then store half@106 wdata=%h", exp1, 32'hBEEF);

        // Reset while waiting for read data, then a stale rd_valid.
        mem_hold = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h108; req_size = 2'b10; req_signed = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check1("rst_op_ren", ren, 1'b1);
        @(negedge clk);
        check1("rst_op_wait_ready", req_ready, 1'b0);
        check1("rst_op_wait_ren", ren, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_hold = 1'b0;
        check1("midrst_ready", req_ready, 1'b1);
        check1("midrst_ren", ren, 1'b0);
        check1("midrst_wen", wen, 1'b0);
        check1("midrst_resp_valid", resp_valid, 1'b0);
        check1("midrst_resp_err", resp_err, 1'b0);
        check("midrst_addr", 32'(addr), 32'd0);
        check("midrst_wdata", wdata, 32'd0);
        check("midrst_wmask", 32'(wmask), 32'd0);
        check("midrst_resp_rdata", resp_rdata, 32'd0);
        inject = 1'b1;
        inject_data = $urandom;
        @(negedge clk);
        inject = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check1("late_rdv_resp_valid", resp_valid, 1'b0);
            check1("late_rdv_ready", req_ready, 1'b1);
            check("late_rdv_rdata", resp_rdata, 32'd0);
            @(negedge clk);
        end
        $display("op reset during LOAD_WAIT, stale rd_valid data=%h ignored", inject_data);

        for (int i = 0; i < 40; i++) begin
            rnd_we = 1'($urandom_range(0, 1));
            rnd_a  = 32'h100 + $urandom_range(0, 63);
            rnd_sz = 2'($urandom_range(0, 3));
            rnd_sg = 1'($urandom_range(0, 1));
            do_op(rnd_we, rnd_a, rnd_sz, rnd_sg, $urandom);
        end

        check("ren_wen_overlap", 32'(overlap), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
